// File: rtl/access_sequencer.sv
// Processor-side request generator: walks an address pattern into the cache, gathers hit/miss/latency stats.
// Optional ACCESS_SEQ_LFSR_EN enables the pseudo-random pattern in mode 2 (otherwise mode 2 == mode 0).
module access_sequencer #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [8:0]       base_addr,
  input  logic [CNT_W-1:0] count,
  input  logic             hit,
  output logic [8:0]       p_address,
  output logic             req,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] max_latency
);

  // state | meaning
  // IDLE  | no run since reset; outputs quiet, waiting for start
  // ISSUE | present p_address for one cycle, arm wait timer
  // WAIT  | sample hit each cycle until hit or timer terminal count
  // DONE  | run finished or aborted; done held until next start

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state, state_nxt;
  logic [1:0]        mode_q;
  logic [CNT_W-1:0]  remaining;
  logic [TMR_W-1:0]  wait_tmr;
  logic              first_sample;
  logic              accept, access_ok, access_to;
  logic [8:0]        next_addr, start_addr;
  logic [31:0]       lat_raw;
  logic [CNT_W-1:0]  lat_sat;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    access_ok = 1'b0;
    access_to = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (hit) begin
          access_ok = 1'b1;
          state_nxt = (remaining == CNT_W'(1)) ? DONE : ISSUE;
        end else if (wait_tmr == '0) begin
          access_to = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req  = (state == ISSUE) || (state == WAIT);
  assign busy = req;

  // Timer counts down from TIMEOUT, so elapsed wait is its distance from the load value.
  assign lat_raw = 32'(TIMEOUT) - 32'(wait_tmr);
  assign lat_sat = (lat_raw > 32'(CNT_MAX)) ? CNT_MAX : lat_raw[CNT_W-1:0];

  always_comb begin
    next_addr = p_address + 9'd1;
    case (mode_q)
      2'd1: next_addr = p_address + 9'd4;
`ifdef ACCESS_SEQ_LFSR_EN
      2'd2: next_addr = {p_address[7:0], p_address[8] ^ p_address[4]};
`endif
      2'd3: next_addr = p_address;
      default: ;
    endcase
  end

  always_comb begin
    start_addr = base_addr;
`ifdef ACCESS_SEQ_LFSR_EN
    // An all-zero LFSR would lock up.
    if (mode == 2'd2 && base_addr == 9'd0) start_addr = 9'h1FF;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q       <= 2'd0;
      remaining    <= '0;
      wait_tmr     <= '0;
      first_sample <= 1'b0;
      p_address    <= 9'd0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
      hit_count    <= '0;
      miss_count   <= '0;
      max_latency  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            mode_q      <= mode;
            remaining   <= count;
            p_address   <= start_addr;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            hit_count   <= '0;
            miss_count  <= '0;
            max_latency <= '0;
          end
        end
        ISSUE: begin
          wait_tmr     <= TMR_W'(TIMEOUT);
          first_sample <= 1'b1;
        end
        WAIT: begin
          first_sample <= 1'b0;
          if (first_sample) begin
            if (hit) begin
              if (hit_count != CNT_MAX) hit_count <= hit_count + CNT_W'(1);
            end else begin
              if (miss_count != CNT_MAX) miss_count <= miss_count + CNT_W'(1);
            end
          end
          if (access_ok) begin
            if (lat_sat > max_latency) max_latency <= lat_sat;
            remaining <= remaining - CNT_W'(1);
            if (state_nxt == DONE) done <= 1'b1;
            else                   p_address <= next_addr;
          end else if (access_to) begin
            timeout_err <= 1'b1;
            done        <= 1'b1;
          end else begin
            wait_tmr <= wait_tmr - TMR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_access_sequencer.sv
// Self-checking bench for access_sequencer: constant vector table, directed corner sequences, random runs vs a reference model.
module tb_access_sequencer;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 64;
`ifdef ACCESS_SEQ_LFSR_EN
  localparam bit LFSR_EN = 1'b1;
`else
  localparam bit LFSR_EN = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset, start, hit;
  logic [1:0]       mode;
  logic [8:0]       base_addr;
  logic [CNT_W-1:0] count;
  logic [8:0]       p_address;
  logic             req, busy, done, timeout_err;
  logic [CNT_W-1:0] hit_count, miss_count, max_latency;

  access_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .base_addr(base_addr),
    .count(count), .hit(hit), .p_address(p_address), .req(req), .busy(busy), .done(done),
    .timeout_err(timeout_err), .hit_count(hit_count), .miss_count(miss_count),
    .max_latency(max_latency)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Observations from the last driven run
  int obs_addr[$];
  int obs_done;
  int busy_err;

  // Drives one run; ks[i] = cycles hit stays low in access i (> TIMEOUT forces an abort).
  task automatic do_run(input logic [8:0] b, input logic [1:0] m, input logic [7:0] cnt, input int ks[$]);
    int n, k;
    bit wave[$];
    bit iss[$];
    n = (cnt == 0) ? (1 << CNT_W) : int'(cnt);
    for (int i = 0; i < n; i++) begin
      k = (i < ks.size()) ? ks[i] : 0;
      iss.push_back(1'b1);
      wave.push_back(1'($urandom_range(0, 1)));  // hit during ISSUE must be ignored
      if (k > TIMEOUT) begin
        repeat (TIMEOUT + 1) begin iss.push_back(1'b0); wave.push_back(1'b0); end
        break;
      end
      repeat (k) begin iss.push_back(1'b0); wave.push_back(1'b0); end
      iss.push_back(1'b0);
      wave.push_back(1'b1);
    end
    @(negedge clock);
    start = 1'b1; base_addr = b; mode = m; count = cnt; hit = 1'b0;
    obs_addr.delete();
    obs_done = -1;
    busy_err = 0;
    for (int c = 0; c < wave.size() + 4; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (done) begin
        obs_done = c;
        break;
      end
      if (!busy || !req) busy_err++;
      if (c < wave.size() && iss[c]) obs_addr.push_back(int'(p_address));
      hit = (c < wave.size()) ? wave[c] : 1'b0;
    end
    hit = 1'b0;
  endtask

  // Reference model
  int exp_addr[$];
  int e_hit, e_miss, e_lat, e_to, e_cyc;

  function automatic int nxt(input int a, input int m);
    case (m)
      0: return (a + 1) % 512;
      1: return (a + 4) % 512;
      2: return LFSR_EN ? (((a * 2) % 512) + (((a / 256) + (a / 16)) % 2)) : (a + 1) % 512;
      default: return a;
    endcase
  endfunction

  task automatic model(input int b, input int m, input int cnt, input int ks[$]);
    int n, a, k;
    exp_addr.delete();
    e_hit = 0; e_miss = 0; e_lat = 0; e_to = 0; e_cyc = 0;
    n = (cnt == 0) ? (1 << CNT_W) : cnt;
    a = b;
    if (m == 2 && LFSR_EN && a == 0) a = 511;
    for (int i = 0; i < n; i++) begin
      k = (i < ks.size()) ? ks[i] : 0;
      exp_addr.push_back(a);
      if (k > TIMEOUT) begin
        e_miss++;
        e_to = 1;
        e_cyc += TIMEOUT + 2;
        break;
      end
      e_cyc += 2 + k;
      if (k == 0) e_hit++;
      else begin
        e_miss++;
        if (k > e_lat) e_lat = k;
      end
      a = nxt(a, m);
    end
    if (e_hit > 255) e_hit = 255;
    if (e_miss > 255) e_miss = 255;
  endtask

  typedef struct {
    logic [8:0] base;
    logic [1:0] mode;
    logic [7:0] cnt;
    int         k0;
    logic [8:0] exp_last;
    int         exp_hit;
    int         exp_miss;
    int         exp_lat;
    int         exp_to;
    int         exp_cyc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ks[$];
    int mism;
    vecs[0] = '{9'h010, 2'd0, 8'd4, 0,  9'h013, 4,   0, 0,  0, 8};
    vecs[1] = '{9'h1FE, 2'd1, 8'd3, 0,  9'h006, 3,   0, 0,  0, 6};
    vecs[2] = '{9'h055, 2'd3, 8'd2, 3,  9'h055, 1,   1, 3,  0, 7};
    vecs[3] = '{9'h100, 2'd0, 8'd5, 99, 9'h100, 0,   1, 0,  1, 66};
    vecs[4] = '{9'h000, 2'd0, 8'd0, 0,  9'h0FF, 255, 0, 0,  0, 512};
    vecs[5] = '{9'h000, 2'd2, 8'd2, 0,  LFSR_EN ? 9'h1FE : 9'h001, 2, 0, 0, 0, 4};
    vecs[6] = '{9'h1FF, 2'd0, 8'd2, 0,  9'h000, 2,   0, 0,  0, 4};
    vecs[7] = '{9'h020, 2'd1, 8'd1, 64, 9'h020, 0,   1, 64, 0, 66};

    reset = 1'b1; start = 1'b0; hit = 1'b0; mode = 2'd0; base_addr = 9'd0; count = '0;
    repeat (3) @(negedge clock);
    check("rst_p_address", p_address, 0);
    check("rst_req", req, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_hit_count", hit_count, 0);
    check("rst_miss_count", miss_count, 0);
    check("rst_max_latency", max_latency, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      ks.delete();
      ks.push_back(vecs[i].k0);
      do_run(vecs[i].base, vecs[i].mode, vecs[i].cnt, ks);
      check($sformatf("v%0d_cycles", i), obs_done, vecs[i].exp_cyc);
      check($sformatf("v%0d_busy_gaps", i), busy_err, 0);
      check($sformatf("v%0d_first_addr", i), obs_addr.size() > 0 ? obs_addr[0] : -1,
            (vecs[i].mode == 2 && LFSR_EN && vecs[i].base == 0) ? 'h1FF : int'(vecs[i].base));
      check($sformatf("v%0d_last_addr", i), obs_addr.size() > 0 ? obs_addr[$] : -1, int'(vecs[i].exp_last));
      check($sformatf("v%0d_hit_count", i), hit_count, vecs[i].exp_hit);
      check($sformatf("v%0d_miss_count", i), miss_count, vecs[i].exp_miss);
      check($sformatf("v%0d_max_latency", i), max_latency, vecs[i].exp_lat);
      check($sformatf("v%0d_timeout_err", i), timeout_err, vecs[i].exp_to);
      check($sformatf("v%0d_req_after", i), req, 0);
    end

    // Start is ignored in ISSUE/WAIT and on the cycle busy falls; accepted the cycle after.
    @(negedge clock);
    start = 1'b1; base_addr = 9'h040; mode = 2'd0; count = 8'd1; hit = 1'b0;
    @(negedge clock);
    base_addr = 9'h0C0; hit = 1'b1;
    @(negedge clock);
    check("seq_busy_wait", busy, 1);
    check("seq_addr_wait", p_address, 'h040);
    hit = 1'b1;
    @(negedge clock);
    check("seq_done_rise", done, 1);
    check("seq_busy_fall", busy, 0);
    check("seq_hit_before", hit_count, 1);
    @(negedge clock);
    start = 1'b0;
    check("seq_restart_busy", busy, 1);
    check("seq_restart_done", done, 0);
    check("seq_restart_addr", p_address, 'h0C0);
    check("seq_restart_clear", hit_count, 0);
    hit = 1'b1;
    for (int c = 0; c < 6 && !done; c++) @(negedge clock);
    hit = 1'b0;
    check("seq_restart_finish", done, 1);
    check("seq_restart_hits", hit_count, 1);
    repeat (3) @(negedge clock);
    check("seq_done_held", done, 1);
    check("seq_addr_held", p_address, 'h0C0);
    check("seq_req_idle", req, 0);

    // Reset in the middle of WAIT
    start = 1'b1; base_addr = 9'h0AA; mode = 2'd0; count = 8'd3; hit = 1'b0;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("mid_miss_seen", miss_count, 1);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_p_address", p_address, 0);
    check("mid_rst_req", req, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_miss", miss_count, 0);
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_stays_idle", busy, 0);

    // Random runs against the reference model
    for (int r = 0; r < 24; r++) begin
      int b, m, cnt, sel;
      b   = $urandom_range(0, 511);
      m   = $urandom_range(0, 3);
      cnt = $urandom_range(1, 12);
      if (r % 6 == 0) b = 0;
      ks.delete();
      for (int i = 0; i < cnt; i++) begin
        sel = $urandom_range(0, 19);
        if (sel < 10)       ks.push_back(0);
        else if (sel < 17)  ks.push_back($urandom_range(1, 6));
        else if (sel == 17) ks.push_back(TIMEOUT);
        else if (sel == 18) ks.push_back(TIMEOUT - 1);
        else                ks.push_back(TIMEOUT + 6);
      end
      model(b, m, cnt, ks);
      do_run(9'(b), 2'(m), 8'(cnt), ks);
      mism = 0;
      for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++)
        if (obs_addr[i] != exp_addr[i]) mism++;
      check($sformatf("r%0d_addr_len", r), obs_addr.size(), exp_addr.size());
      check($sformatf("r%0d_addr_mism", r), mism, 0);
      check($sformatf("r%0d_cycles", r), obs_done, e_cyc);
      check($sformatf("r%0d_hit_count", r), hit_count, e_hit);
      check($sformatf("r%0d_miss_count", r), miss_count, e_miss);
      check($sformatf("r%0d_max_latency", r), max_latency, e_lat);
      check($sformatf("r%0d_timeout_err", r), timeout_err, e_to);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/access_sequencer.md
# access_sequencer

Processor-side request generator sitting directly upstream of the cache controller. It drives the 9-bit processor address into the cache, waits for the cache's hit indication before advancing, and walks a programmed access pattern. It also accumulates hit/miss statistics and the worst-case miss service latency for display and bench checking.

## Interface

Parameters:
- CNT_W, 8, width of access count and statistics counters
- TIMEOUT, 64, maximum cycles spent waiting on one access before abort

Ports:
- clock  in  1  single system clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- start  in  1  level sampled each cycle; begins a run when accepted
- mode  in  2  pattern: 0 sequential +1, 1 stride +4 (one 32-bit line), 2 pseudo-random, 3 repeat base
- base_addr  in  9  first address of the run (LFSR seed in mode 2)
- count  in  CNT_W  accesses per run; 0 means 2^CNT_W
- hit  in  1  cache hit/valid indication for the presented address
- p_address  out  9  address presented to cache controller, registered
- req  out  1  high while p_address is a live request
- busy  out  1  run in progress
- done  out  1  run finished; held until next accepted start or reset
- timeout_err  out  1  last run aborted by TIMEOUT; held like done
- hit_count  out  CNT_W  accesses hit on first sample, saturating
- miss_count  out  CNT_W  accesses missed on first sample, saturating
- max_latency  out  CNT_W  largest wait (cycles) of any access this run, saturating

## Operation

- States: IDLE, ISSUE, WAIT, DONE.
- IDLE/DONE: start=1 -> latch mode, count into remaining; p_address<=base_addr; clear hit_count, miss_count, max_latency, timeout_err, done; go ISSUE. start ignored in ISSUE/WAIT.
- ISSUE (1 cycle): req=1, wait counter<=0; go WAIT.
- WAIT: first WAIT cycle is the first sample. hit=1 on first sample -> hit_count+1. hit=0 on first sample -> miss_count+1 (once per access), keep waiting, wait counter+1 each cycle.
- On hit=1 in WAIT: max_latency<=max(max_latency, wait counter); remaining-1; if remaining was 1 -> DONE, else next address and ISSUE.
- Wait counter reaching TIMEOUT with hit=0 -> timeout_err=1, DONE; access not counted as completed.
- Next address: mode 0: +1; mode 1: +4; mode 2: 9-bit Fibonacci LFSR, taps x^9+x^5+1, shift-left, new bit0 = bit8^bit4; mode 3: unchanged. All arithmetic mod 512 (wrap 511->0, 510+4->2).
- LFSR seed 0 replaced by 9'h1FF at start.
- Counters saturate at 2^CNT_W-1; no wrap.
- req=0 in IDLE and DONE; p_address holds last value.

## Timing

- Reset values: p_address=0, req=0, busy=0, done=0, timeout_err=0, hit_count=0, miss_count=0, max_latency=0, state IDLE. Reset mid-run aborts immediately, no done.
- start accepted at edge N -> req=1, busy=1, p_address=base_addr after edge N.
- Hit access: 2 cycles per access (ISSUE + one WAIT); n all-hit accesses -> done asserts 2n cycles after acceptance.
- Miss with hit rising after k extra cycles: access takes 2+k cycles; recorded latency k.
- busy falls and done rises on the same edge; start in that cycle ignored, start in the next cycle accepted.
- Counter updates visible the edge after the sampling cycle.

## Configuration

- ACCESS_SEQ_LFSR_EN defined: mode 2 uses the LFSR above.
- Not defined: LFSR logic removed; mode 2 behaves exactly as mode 0.

## Test plan

- base_addr=0x010, mode 0, count=4, hit tied 1 -> addresses 0x010..0x013, hit_count=4, miss_count=0, max_latency=0, done 8 cycles after start.
- base_addr=0x1FE, mode 1, count=3, hit=1 -> addresses 0x1FE, 0x002, 0x006 (wrap).
- mode 3, count=2, hit low 3 cycles after first ISSUE then high -> miss_count=1, hit_count=1, max_latency=3.
- hit tied 0, count=5 -> timeout_err=1 and done after TIMEOUT+1 WAIT cycles, miss_count=1.
- count=0, mode 0, hit=1 -> 256 accesses, hit_count saturates at 255, done at 512 cycles.
- reset asserted during WAIT -> all outputs return to reset values next edge; mode 2 base_addr=0 (macro on) -> first two addresses 0x1FF, 0x1FE.
